comparador_serial: RTL and testbench

//  Multi-cycle parametrised magnitude comparator, successor to the 4-bit 7485-style combinational comparator.

---
 rtl/comparador_serial.sv | 137 +++++++++++++
 tb/tb_comparador_serial.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/comparador_serial.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands DIGIT bits per cycle, MSB digit first,
// stopping at the first unequal digit; 7485-style cascade inputs decide the result on equality.
module comparador_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             iniciar,
  input  logic             sinal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ALBi,
  input  logic             AGBi,
  input  logic             AEBi,
  output logic             ALBo,
  output logic             AGBo,
  output logic             AEBo,
  output logic             ocupado,
  output logic             pronto
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, COMPARA, FIM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       cas_q, cas_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             alb_q, alb_d, agb_q, agb_d, aeb_q, aeb_d;
  logic             ocupado_q, ocupado_d, pronto_q, pronto_d;

  logic [WIDTH-1:0] a_flip, b_flip, a_shift, b_shift;
  logic [DIGIT-1:0] dig_a, dig_b;

  // Signed mode becomes an unsigned compare once both sign bits are inverted.
  always_comb begin
    a_flip            = A;
    b_flip            = B;
    a_flip[WIDTH-1]   = A[WIDTH-1] ^ sinal;
    b_flip[WIDTH-1]   = B[WIDTH-1] ^ sinal;
  end

  // Operands are shifted left so the digit under test is always the top one.
  if (NDIG > 1) begin : g_shift
    assign a_shift = {a_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
    assign b_shift = {b_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
  end else begin : g_noshift
    assign a_shift = a_q;
    assign b_shift = b_q;
  end

  assign dig_a = a_q[WIDTH-1 -: DIGIT];
  assign dig_b = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cas_d    = cas_q;
    idx_d    = idx_q;
    alb_d    = alb_q;
    agb_d    = agb_q;
    aeb_d    = aeb_q;
    pronto_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iniciar) begin
          a_d     = a_flip;
          b_d     = b_flip;
          cas_d   = {ALBi, AGBi, AEBi};
          idx_d   = IDXW'(NDIG - 1);
          alb_d   = 1'b0;
          agb_d   = 1'b0;
          aeb_d   = 1'b0;
          state_d = COMPARA;
        end
      end
      COMPARA: begin
        if (dig_a != dig_b) begin
          alb_d   = (dig_a < dig_b);
          agb_d   = (dig_a > dig_b);
          aeb_d   = 1'b0;
          state_d = FIM;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IDXW'(1);
          a_d   = a_shift;
          b_d   = b_shift;
        end else begin
          {alb_d, agb_d, aeb_d} = cas_q;
          state_d               = FIM;
        end
      end
      FIM: begin
        pronto_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ocupado_d = (state_d == COMPARA);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cas_q     <= '0;
      idx_q     <= '0;
      alb_q     <= 1'b0;
      agb_q     <= 1'b0;
      aeb_q     <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cas_q     <= cas_d;
      idx_q     <= idx_d;
      alb_q     <= alb_d;
      agb_q     <= agb_d;
      aeb_q     <= aeb_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  assign ALBo    = alb_q;
  assign AGBo    = agb_q;
  assign AEBo    = aeb_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Randomized self-checking bench for comparador_serial (16/4 and 8/8 instances) against an
// arithmetic reference model.
module tb_comparador_serial;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ini16, ini8, sinal;
  logic [15:0] a_in, b_in;
  logic        albi, agbi, aebi;
  logic        alb16, agb16, aeb16, ocu16, pr16;
  logic        alb8, agb8, aeb8, ocu8, pr8;
  bit          sel8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  comparador_serial #(.WIDTH(16), .DIGIT(4)) u16 (
    .clock(clock), .reset_n(reset_n), .iniciar(ini16), .sinal(sinal),
    .A(a_in), .B(b_in), .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
    .ALBo(alb16), .AGBo(agb16), .AEBo(aeb16), .ocupado(ocu16), .pronto(pr16)
  );

  comparador_serial #(.WIDTH(8), .DIGIT(8)) u8 (
    .clock(clock), .reset_n(reset_n), .iniciar(ini8), .sinal(sinal),
    .A(a_in[7:0]), .B(b_in[7:0]), .ALBi(albi), .AGBi(agbi), .AEBi(aebi),
    .ALBo(alb8), .AGBo(agb8), .AEBo(aeb8), .ocupado(ocu8), .pronto(pr8)
  );

  logic [2:0] obs_res;
  logic       obs_pr, obs_ocu;
  assign obs_res = sel8 ? {alb8, agb8, aeb8} : {alb16, agb16, aeb16};
  assign obs_pr  = sel8 ? pr8  : pr16;
  assign obs_ocu = sel8 ? ocu8 : ocu16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic; cascade bits on equality.
  function automatic logic [2:0] model_res(input longint a, input longint b, input bit s,
                                           input int w, input logic [2:0] cas);
    longint sa = a, sb = b;
    if (s && a[w-1]) sa = a - (longint'(1) << w);
    if (s && b[w-1]) sb = b - (longint'(1) << w);
    if (sa < sb) return 3'b100;
    if (sa > sb) return 3'b010;
    return cas;
  endfunction

  // Digits examined: position of the most significant differing digit, or all of them.
  function automatic int model_k(input longint a, input longint b, input int w, input int d);
    int ndig = w / d;
    longint mask = (longint'(1) << d) - 1;
    for (int i = ndig - 1; i >= 0; i--)
      if (((a >> (i * d)) & mask) != ((b >> (i * d)) & mask)) return ndig - i;
    return ndig;
  endfunction

  task automatic run_cmp(input string tag, input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input logic [2:0] cas);
    int         w = w8 ? 8 : 16;
    int         d = w8 ? 8 : 4;
    logic [15:0] am = w8 ? {8'h00, a[7:0]} : a;
    logic [15:0] bm = w8 ? {8'h00, b[7:0]} : b;
    logic [2:0] exp_r = model_res(longint'(am), longint'(bm), s, w, cas);
    int         exp_k = model_k(longint'(am), longint'(bm), w, d);
    int         n = 0;
    bit         seen = 0;
    sel8 = w8;
    @(negedge clock);
    a_in = a; b_in = b; sinal = s; {albi, agbi, aebi} = cas;
    if (w8) ini8 = 1'b1; else ini16 = 1'b1;
    @(negedge clock);
    ini8 = 1'b0; ini16 = 1'b0;
    check({tag, "_clr"}, 32'(obs_res), 32'd0);
    check({tag, "_busy"}, 32'(obs_ocu), 32'd1);
    a_in = 16'($urandom); b_in = 16'($urandom); sinal = ~s; {albi, agbi, aebi} = ~cas;
    while (n < 30 && !seen) begin
      @(negedge clock);
      n++;
      if (obs_pr) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"}, 32'(n), 32'(exp_k + 1));
      check({tag, "_res"}, 32'(obs_res), 32'(exp_r));
      @(negedge clock);
      check({tag, "_pulse"}, 32'(obs_pr), 32'd0);
      check({tag, "_hold"}, 32'(obs_res), 32'(exp_r));
    end
  endtask

  initial begin
    int prs;
    logic [15:0] ra, rb;
    reset_n = 1'b0; ini16 = 1'b0; ini8 = 1'b0; sinal = 1'b0;
    a_in = '0; b_in = '0; {albi, agbi, aebi} = 3'b000; sel8 = 0;
    repeat (3) @(negedge clock);
    check("rst16_out", 32'({alb16, agb16, aeb16, ocu16, pr16}), 32'd0);
    check("rst8_out", 32'({alb8, agb8, aeb8, ocu8, pr8}), 32'd0);
    reset_n = 1'b1;

    run_cmp("uns_early", 0, 16'h1234, 16'h1243, 0, 3'b000);
    run_cmp("mode_uns", 0, 16'hA000, 16'h1000, 0, 3'b000);
    run_cmp("mode_sgn", 0, 16'hA000, 16'h1000, 1, 3'b000);
    run_cmp("eq_001", 0, 16'h5A5A, 16'h5A5A, 0, 3'b001);
    run_cmp("eq_010", 0, 16'h5A5A, 16'h5A5A, 1, 3'b010);
    run_cmp("eq_111", 0, 16'h0000, 16'h0000, 0, 3'b111);
    run_cmp("w8_sgn", 1, 16'h0080, 16'h007F, 1, 3'b000);
    run_cmp("w8_uns", 1, 16'h0080, 16'h007F, 0, 3'b000);
    run_cmp("w8_eq", 1, 16'h00C3, 16'h00C3, 0, 3'b100);

    // Re-pulsed start during COMPARA must be ignored.
    sel8 = 0;
    @(negedge clock);
    a_in = 16'd1; b_in = 16'd2; sinal = 0; {albi, agbi, aebi} = 3'b000; ini16 = 1'b1;
    @(negedge clock);
    ini16 = 1'b0; a_in = 16'd9;
    @(negedge clock);
    ini16 = 1'b1;
    @(negedge clock);
    ini16 = 1'b0;
    prs = 0;
    repeat (12) begin
      @(negedge clock);
      if (pr16) prs++;
    end
    check("busy_prontos", 32'(prs), 32'd1);
    check("busy_res", 32'({alb16, agb16, aeb16}), 32'b100);

    // Reset in the middle of a compare aborts it without a pronto.
    run_cmp("pre_rst", 0, 16'h5A5A, 16'h5A5A, 0, 3'b010);
    @(negedge clock);
    a_in = 16'h7777; b_in = 16'h7777; {albi, agbi, aebi} = 3'b001; ini16 = 1'b1;
    @(negedge clock);
    ini16 = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_out", 32'({alb16, agb16, aeb16, ocu16, pr16}), 32'd0);
    reset_n = 1'b1;
    prs = 0;
    repeat (8) begin
      @(negedge clock);
      if (pr16) prs++;
    end
    check("midrst_nopronto", 32'(prs), 32'd0);
    check("midrst_idle", 32'({alb16, agb16, aeb16, ocu16}), 32'd0);
    run_cmp("post_rst", 0, 16'h8001, 16'h8000, 1, 3'b000);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rb = 16'($urandom);
        1: rb = ra;
        default: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
      endcase
      run_cmp($sformatf("rnd%0d", i), bit'(i % 3 == 2), ra, rb, bit'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
